// File: rtl/hub75_bcm_scan.sv
// rtl/hub75_bcm_scan.sv - HUB75 panel scanner with BCM bit planes, global dimming and double-buffered frames
module hub75_bcm_scan #(
    parameter int ROW_BITS     = 3,
    parameter int COL_BITS     = 5,
    parameter int COLOR_BITS   = 8,
    parameter int BLANK_CYCLES = 32,
    parameter int SHOW_BASE    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [1:0]                   dim,
    input  logic                         swap_req,
    output logic                         swap_ack,
    output logic                         front_sel,
    output logic [ROW_BITS+COL_BITS:0]   pix_addr,
    input  logic [6*COLOR_BITS-1:0]      pix_data,
    output logic [ROW_BITS-1:0]          row_addr,
    output logic [2:0]                   rgb0,
    output logic [2:0]                   rgb1,
    output logic                         rgb_clk,
    output logic                         rgb_stb,
    output logic                         oe_n,
    output logic                         frame_start
);
    localparam int PLANE_W  = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int SHOW_MAX = SHOW_BASE << (COLOR_BITS - 1);
    localparam int SHOW_W   = $clog2(SHOW_MAX + 1);
    localparam int BLANK_W  = $clog2(BLANK_CYCLES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_CLOCK  = 3'd3;
    localparam logic [2:0] S_BLANK  = 3'd4;
    localparam logic [2:0] S_LATCH  = 3'd5;
    localparam logic [2:0] S_SHOW   = 3'd6;
    localparam logic [2:0] S_FRAME  = 3'd7;

    logic [2:0]            state, state_n;
    logic [ROW_BITS-1:0]   row, row_n;
    logic [COL_BITS-1:0]   col, col_n;
    logic [PLANE_W-1:0]    plane, plane_n;
    logic                  front_n, swap_n, fs_n;
    logic [BLANK_W-1:0]    blank_cnt;
    logic [SHOW_W-1:0]     show_cnt, show_len, show_on, plane_len;
    logic [COLOR_BITS-1:0] ru, gu, bu, rl, gl, bl;

    assign {ru, gu, bu, rl, gl, bl} = pix_data;
    assign plane_len = SHOW_W'(SHOW_BASE) << plane;

    // Next-value view of the counters so pix_addr is already valid during FETCH.
    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        plane_n = plane;
        front_n = front_sel;
        swap_n  = 1'b0;
        fs_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_n = S_FETCH;
                    row_n   = '0;
                    col_n   = '0;
                    plane_n = '0;
                    fs_n    = 1'b1;
                end
            end
            S_FETCH:  state_n = S_SAMPLE;
            S_SAMPLE: state_n = S_CLOCK;
            S_CLOCK: begin
                col_n   = col + COL_BITS'(1);
                state_n = (&col) ? S_BLANK : S_FETCH;
            end
            S_BLANK: begin
                if (blank_cnt == BLANK_W'(BLANK_CYCLES - 1)) state_n = S_LATCH;
            end
            S_LATCH: state_n = S_SHOW;
            S_SHOW: begin
                if (show_cnt == show_len - SHOW_W'(1)) begin
                    if (plane == PLANE_W'(COLOR_BITS - 1)) begin
                        plane_n = '0;
                        row_n   = row + ROW_BITS'(1);
                        if (&row) begin
                            state_n = S_FRAME;
                            fs_n    = 1'b1;
                            if (swap_req) begin
                                front_n = ~front_sel;
                                swap_n  = 1'b1;
                            end
                        end else begin
                            state_n = S_FETCH;
                        end
                    end else begin
                        plane_n = plane + PLANE_W'(1);
                        state_n = S_FETCH;
                    end
                end
            end
            S_FRAME: state_n = enable ? S_FETCH : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            row         <= '0;
            col         <= '0;
            plane       <= '0;
            front_sel   <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            pix_addr    <= '0;
            row_addr    <= '0;
            rgb0        <= '0;
            rgb1        <= '0;
            rgb_clk     <= 1'b0;
            rgb_stb     <= 1'b0;
            oe_n        <= 1'b1;
            blank_cnt   <= '0;
            show_cnt    <= '0;
            show_len    <= '0;
            show_on     <= '0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            col         <= col_n;
            plane       <= plane_n;
            front_sel   <= front_n;
            swap_ack    <= swap_n;
            frame_start <= fs_n;
            rgb_clk     <= (state_n == S_CLOCK);
            rgb_stb     <= (state_n == S_LATCH);
            if (state_n == S_FETCH) pix_addr <= {front_n, row_n, col_n};
            if (state == S_SAMPLE) begin
                rgb0 <= {ru[plane], gu[plane], bu[plane]};
                rgb1 <= {rl[plane], gl[plane], bl[plane]};
            end
            // Row lines only move here, where oe_n is guaranteed high.
            if (state_n == S_BLANK && state != S_BLANK) begin
                row_addr  <= row;
                blank_cnt <= '0;
            end else if (state == S_BLANK) begin
                blank_cnt <= blank_cnt + BLANK_W'(1);
            end
            if (state == S_LATCH) begin
                show_len <= plane_len;
                show_on  <= plane_len >> dim;
                show_cnt <= '0;
                oe_n     <= ((plane_len >> dim) == '0);
            end else if (state == S_SHOW && state_n == S_SHOW) begin
                show_cnt <= show_cnt + SHOW_W'(1);
                oe_n     <= !((show_cnt + SHOW_W'(1)) < show_on);
            end else begin
                oe_n <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hub75_bcm_scan.sv
// tb/tb_hub75_bcm_scan.sv - randomized self-checking bench for hub75_bcm_scan
module tb_hub75_bcm_scan;
    localparam int ROW_BITS     = 1;
    localparam int COL_BITS     = 2;
    localparam int COLOR_BITS   = 2;
    localparam int BLANK_CYCLES = 2;
    localparam int SHOW_BASE    = 4;
    localparam int ROWS = 1 << ROW_BITS;
    localparam int COLS = 1 << COL_BITS;
    localparam int AW   = 1 + ROW_BITS + COL_BITS;
    localparam int DW   = 6 * COLOR_BITS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    dim = 2'd0;
    logic          swap_req = 1'b0;
    logic          swap_ack, front_sel, rgb_clk, rgb_stb, oe_n, frame_start;
    logic [AW-1:0] pix_addr;
    logic [DW-1:0] pix_data;
    logic [ROW_BITS-1:0] row_addr;
    logic [2:0]    rgb0, rgb1;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int  tests_run = 0;
    int  tests_failed = 0;
    logic exp_front = 1'b0;

    hub75_bcm_scan #(
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .COLOR_BITS(COLOR_BITS),
        .BLANK_CYCLES(BLANK_CYCLES), .SHOW_BASE(SHOW_BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .dim(dim),
        .swap_req(swap_req), .swap_ack(swap_ack), .front_sel(front_sel),
        .pix_addr(pix_addr), .pix_data(pix_data), .row_addr(row_addr),
        .rgb0(rgb0), .rgb1(rgb1), .rgb_clk(rgb_clk), .rgb_stb(rgb_stb),
        .oe_n(oe_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Frame RAM with one cycle of read latency.
    always @(posedge clk) pix_data <= mem[pix_addr];

    function automatic logic [2:0] exp_rgb(input logic [DW-1:0] w, input int p, input int half);
        logic [2:0]    res;
        logic [DW-1:0] t;
        for (int ch = 0; ch < 3; ch++) begin
            t = w >> ((half * 3 + 2 - ch) * COLOR_BITS + p);
            res[2-ch] = t[0];
        end
        return res;
    endfunction

    function automatic int period(input int p);
        return 3 * COLS + BLANK_CYCLES + 1 + (SHOW_BASE << p);
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({oe_n, rgb_clk, rgb_stb, front_sel, swap_ack, frame_start} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL reset_ctrl got oe/clk/stb/front/ack/fs=%b expected 100000",
                     {oe_n, rgb_clk, rgb_stb, front_sel, swap_ack, frame_start});
        end
        tests_run++;
        if ({pix_addr, row_addr, rgb0, rgb1} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data got addr=%h row=%h rgb0=%b rgb1=%b expected all 0",
                     pix_addr, row_addr, rgb0, rgb1);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({oe_n, rgb_clk, frame_start} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_idle got oe/clk/fs=%b expected 100", {oe_n, rgb_clk, frame_start});
        end
    endtask

    task automatic test_scan_data(input bit fixed);
        logic [5:0] q[$];
        logic [5:0] e;
        int n, addr;
        dim = 2'd0;
        enable = 1'b1;
        n = 0;
        while (frame_start !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        tests_run++;
        if (frame_start !== 1'b1) begin tests_failed++; $display("FAIL scan_sync frame_start=%b expected 1", frame_start); end
        for (int a = 0; a < (1 << AW); a++) mem[a] = fixed ? 12'b01_10_11_00_01_10 : DW'($urandom);
        for (int r = 0; r < ROWS; r++)
            for (int p = 0; p < COLOR_BITS; p++)
                for (int c = 0; c < COLS; c++) begin
                    addr = (int'(exp_front) << (ROW_BITS + COL_BITS)) | (r << COL_BITS) | c;
                    q.push_back({exp_rgb(mem[addr], p, 1), exp_rgb(mem[addr], p, 0)});
                end
        n = 0;
        do begin
            @(negedge clk); n++;
            if (rgb_clk === 1'b1) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scan_extra_clk got pulse rgb0=%b rgb1=%b expected none", rgb0, rgb1);
                end else begin
                    e = q.pop_front();
                    if ({rgb0, rgb1} !== e) begin
                        tests_failed++;
                        $display("FAIL scan_rgb got rgb0=%b rgb1=%b expected rgb0=%b rgb1=%b",
                                 rgb0, rgb1, e[5:3], e[2:0]);
                    end
                end
            end
        end while (frame_start !== 1'b1 && n < 400);
        tests_run++;
        if (q.size() != 0 || n >= 400) begin
            tests_failed++;
            $display("FAIL scan_frame_end got %0d pulses missing after %0d cycles expected 0", q.size(), n);
        end
    endtask

    task automatic test_dimming(input int d);
        int exp_len[$];
        int exp_row[$];
        int n, run_len, run_row, on, e_len, e_row;
        bit in_run, row_moved;
        n = 0;
        while (frame_start !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        tests_run++;
        if (frame_start !== 1'b1) begin tests_failed++; $display("FAIL dim_sync frame_start=%b expected 1", frame_start); end
        dim = 2'(d);
        for (int r = 0; r < ROWS; r++)
            for (int p = 0; p < COLOR_BITS; p++) begin
                on = (SHOW_BASE << p) >> d;
                if (on > 0) begin exp_len.push_back(on); exp_row.push_back(r); end
            end
        in_run = 1'b0; run_len = 0; run_row = 0; row_moved = 1'b0; n = 0;
        do begin
            @(negedge clk); n++;
            if (oe_n === 1'b0) begin
                if (!in_run) begin in_run = 1'b1; run_len = 0; run_row = int'(row_addr); row_moved = 1'b0; end
                run_len++;
                if (int'(row_addr) != run_row) row_moved = 1'b1;
            end else if (in_run) begin
                in_run = 1'b0;
                tests_run++;
                if (exp_len.size() == 0) begin
                    tests_failed++;
                    $display("FAIL dim_extra_run dim=%0d got run of %0d expected none", d, run_len);
                end else begin
                    e_len = exp_len.pop_front();
                    e_row = exp_row.pop_front();
                    if (run_len != e_len) begin
                        tests_failed++;
                        $display("FAIL dim_on_len dim=%0d got %0d expected %0d", d, run_len, e_len);
                    end
                    tests_run++;
                    if (run_row != e_row || row_moved) begin
                        tests_failed++;
                        $display("FAIL dim_row_addr dim=%0d got row %0d moved=%0d expected row %0d moved=0",
                                 d, run_row, row_moved, e_row);
                    end
                end
            end
        end while (frame_start !== 1'b1 && n < 400);
        tests_run++;
        if (exp_len.size() != 0 || in_run) begin
            tests_failed++;
            $display("FAIL dim_runs_missing dim=%0d got %0d runs unseen expected 0", d, exp_len.size());
        end
    endtask

    task automatic test_timing();
        int stb_t[$];
        int fs_t[$];
        int t, clks, exp_iv, k;
        t = 0;
        while (frame_start !== 1'b1 && t < 300) begin @(negedge clk); t++; end
        tests_run++;
        if (frame_start !== 1'b1) begin tests_failed++; $display("FAIL time_sync frame_start=%b expected 1", frame_start); end
        dim = 2'($urandom_range(0, 3));
        t = 0; clks = 0;
        fs_t.push_back(0);
        do begin
            @(negedge clk); t++;
            if (rgb_clk === 1'b1) clks++;
            if (rgb_stb === 1'b1) begin
                tests_run++;
                if (clks != COLS) begin
                    tests_failed++;
                    $display("FAIL time_clks_per_plane got %0d expected %0d", clks, COLS);
                end
                clks = 0;
                stb_t.push_back(t);
            end
            if (frame_start === 1'b1) begin
                fs_t.push_back(t);
                tests_run++;
                if (swap_ack !== 1'b0 || front_sel !== exp_front) begin
                    tests_failed++;
                    $display("FAIL time_no_swap got ack=%b front=%b expected ack=0 front=%b", swap_ack, front_sel, exp_front);
                end
            end
        end while (fs_t.size() < 3 && t < 600);
        tests_run++;
        if (fs_t.size() != 3 || stb_t.size() != 2 * ROWS * COLOR_BITS) begin
            tests_failed++;
            $display("FAIL time_counts got %0d frames %0d latches expected 2 frames %0d latches",
                     fs_t.size() - 1, stb_t.size(), 2 * ROWS * COLOR_BITS);
        end else begin
            for (int f = 1; f < 3; f++) begin
                tests_run++;
                if (fs_t[f] - fs_t[f-1] != ROWS * (period(0) + period(1)) + 1) begin
                    tests_failed++;
                    $display("FAIL time_frame_period got %0d expected %0d", fs_t[f] - fs_t[f-1],
                             ROWS * (period(0) + period(1)) + 1);
                end
            end
            for (k = 1; k < stb_t.size(); k++) begin
                exp_iv = period((k - 1) % COLOR_BITS) + ((k % (ROWS * COLOR_BITS)) == 0 ? 1 : 0);
                tests_run++;
                if (stb_t[k] - stb_t[k-1] != exp_iv) begin
                    tests_failed++;
                    $display("FAIL time_plane_period idx=%0d got %0d expected %0d", k, stb_t[k] - stb_t[k-1], exp_iv);
                end
            end
        end
    endtask

    task automatic test_swap();
        int n;
        bit early;
        n = 0;
        while (frame_start !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        tests_run++;
        if (frame_start !== 1'b1) begin tests_failed++; $display("FAIL swap_sync frame_start=%b expected 1", frame_start); end
        repeat ($urandom_range(5, 70)) @(negedge clk);
        swap_req = 1'b1;
        early = 1'b0; n = 0;
        do begin
            @(negedge clk); n++;
            if (frame_start !== 1'b1 && (front_sel !== exp_front || swap_ack !== 1'b0)) early = 1'b1;
        end while (frame_start !== 1'b1 && n < 300);
        tests_run++;
        if (early) begin tests_failed++; $display("FAIL swap_early got change before boundary expected none"); end
        tests_run++;
        if (frame_start !== 1'b1 || swap_ack !== 1'b1 || front_sel !== ~exp_front) begin
            tests_failed++;
            $display("FAIL swap_boundary got fs=%b ack=%b front=%b expected fs=1 ack=1 front=%b",
                     frame_start, swap_ack, front_sel, ~exp_front);
        end
        exp_front = ~exp_front;
        swap_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (swap_ack !== 1'b0 || pix_addr !== {exp_front, {(AW-1){1'b0}}}) begin
            tests_failed++;
            $display("FAIL swap_next_addr got ack=%b addr=%b expected ack=0 addr=%b",
                     swap_ack, pix_addr, {exp_front, {(AW-1){1'b0}}});
        end
    endtask

    task automatic test_enable_off();
        int n, stbs, bad;
        n = 0;
        while (frame_start !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        tests_run++;
        if (frame_start !== 1'b1) begin tests_failed++; $display("FAIL off_sync frame_start=%b expected 1", frame_start); end
        stbs = 0;
        repeat ($urandom_range(1, 80)) begin
            @(negedge clk);
            if (rgb_stb === 1'b1) stbs++;
        end
        enable = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (rgb_stb === 1'b1) stbs++;
        end while (frame_start !== 1'b1 && n < 300);
        tests_run++;
        if (stbs != ROWS * COLOR_BITS || frame_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL off_frame_complete got %0d latches fs=%b expected %0d latches fs=1",
                     stbs, frame_start, ROWS * COLOR_BITS);
        end
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (rgb_clk !== 1'b0 || oe_n !== 1'b1 || frame_start !== 1'b0 || rgb_stb !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL off_idle got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_show();
        int n;
        dim = 2'd0;
        enable = 1'b1;
        n = 0;
        while (!(oe_n === 1'b0 && row_addr === ROW_BITS'(1)) && n < 400) begin @(negedge clk); n++; end
        tests_run++;
        if (oe_n !== 1'b0) begin tests_failed++; $display("FAIL rst_show_reach got oe_n=%b expected 0", oe_n); end
        #2 rst_n = 1'b0;
        #1;
        exp_front = 1'b0;
        tests_run++;
        if (oe_n !== 1'b1 || rgb_stb !== 1'b0 || front_sel !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async got oe_n=%b stb=%b front=%b expected 1 0 0", oe_n, rgb_stb, front_sel);
        end
        tests_run++;
        if (row_addr !== '0 || pix_addr !== '0 || rgb_clk !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async_data got row=%h addr=%h clk=%b expected 0 0 0", row_addr, pix_addr, rgb_clk);
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++;
        if (oe_n !== 1'b1 || frame_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_after got oe_n=%b fs=%b expected 1 0", oe_n, frame_start);
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        test_reset();
        test_scan_data(1'b1);
        test_scan_data(1'b0);
        test_dimming(0);
        test_dimming(2);
        test_dimming(3);
        test_dimming($urandom_range(0, 3));
        test_timing();
        test_swap();
        test_scan_data(1'b0);
        test_enable_off();
        test_reset_mid_show();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
